// File: rtl/spectrum_draw_if.sv
// Bin stream, Avalon-MM pixel write master and buffer-swap handshake
// master: the draw controller side; slave: FFT source, SDRAM and pixel DMA
interface spectrum_draw_if #(
  parameter int MAG_W = 16
);
  logic [MAG_W-1:0] bin_mag;
  logic             bin_valid;
  logic             bin_ready;
  logic [31:0]      m_address;
  logic [15:0]      m_writedata;
  logic             m_write;
  logic             m_waitrequest;
  logic             swap_req;
  logic             swap_done;

  modport master (
    input  bin_mag,
    input  bin_valid,
    output bin_ready,
    output m_address,
    output m_writedata,
    output m_write,
    input  m_waitrequest,
    output swap_req,
    input  swap_done
  );

  modport slave (
    output bin_mag,
    output bin_valid,
    input  bin_ready,
    input  m_address,
    input  m_writedata,
    input  m_write,
    output m_waitrequest,
    input  swap_req,
    output swap_done
  );
endinterface

// File: rtl/spectrum_draw_ctrl.sv
// Spectrum bar renderer: load NUM_BARS bins, draw bars into back buffer, swap.
// Ports: clk, reset (sync, high), enable, colours, bus (bins/Avalon/swap), busy, frame_count
module spectrum_draw_ctrl #(
  parameter int          H_RES     = 320,
  parameter int          V_RES     = 240,
  parameter int          NUM_BARS  = 32,
  parameter int          MAG_W     = 16,
  parameter int          MAG_SHIFT = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [15:0]           bar_color,
  input  logic [15:0]           bg_color,
  spectrum_draw_if.master       bus,
  output logic                  busy,
  output logic [7:0]            frame_count
);

  localparam int BAR_W = H_RES / NUM_BARS;
  localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam int BW = (NUM_BARS > 1) ? $clog2(NUM_BARS) : 1;
  localparam int CW = (BAR_W > 1) ? $clog2(BAR_W) : 1;
  localparam int HW = $clog2(V_RES + 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DRAW,
    SWAP
  } state_t;

  state_t state, state_nx;

  logic [HW-1:0]    h [NUM_BARS];
  logic [BW-1:0]    bin_idx;
  logic [XW-1:0]    x;
  logic [YW-1:0]    y;
  logic [BW-1:0]    bar;
  logic [CW-1:0]    col;
  logic [31:0]      addr;
  logic [15:0]      bar_q;
  logic [15:0]      bg_q;
  logic             swap_q;

  logic             pix_acc;
  logic             last_bin;
  logic             last_pix;
  logic             lit;
  logic [MAG_W-1:0] mag_sh;
  logic [HW-1:0]    h_new;
  logic [HW:0]      h_sum;

  assign mag_sh   = bus.bin_mag >> MAG_SHIFT;
  assign h_new    = (mag_sh >= MAG_W'(V_RES)) ? HW'(V_RES) : HW'(mag_sh);
  assign last_bin = (bin_idx == BW'(NUM_BARS - 1));
  assign last_pix = (x == XW'(H_RES - 1)) && (y == YW'(V_RES - 1));
  assign pix_acc  = (state == DRAW) && !bus.m_waitrequest;

  // y >= V_RES - h rewritten as y + h >= V_RES to stay unsigned
  assign h_sum = (HW+1)'(y) + (HW+1)'(h[bar]);
  assign lit   = (h_sum >= (HW+1)'(V_RES)) && (col != CW'(BAR_W - 1));

  assign bus.m_address = addr;
  assign bus.swap_req  = swap_q;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx        = state;
    bus.bin_ready   = 1'b0;
    bus.m_write     = 1'b0;
    bus.m_writedata = 16'h0000;
    busy            = (state != IDLE);
    unique case (state)
      IDLE: begin
        if (enable) state_nx = LOAD;
      end
      LOAD: begin
        bus.bin_ready = 1'b1;
        if (bus.bin_valid && last_bin) state_nx = DRAW;
      end
      DRAW: begin
        bus.m_write     = 1'b1;
        bus.m_writedata = lit ? bar_q : bg_q;
        if (pix_acc && last_pix) state_nx = SWAP;
      end
      SWAP: begin
        if (bus.swap_done) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_BARS; i++) h[i] <= '0;
      bin_idx     <= '0;
      x           <= '0;
      y           <= '0;
      bar         <= '0;
      col         <= '0;
      addr        <= BASE_ADDR;
      bar_q       <= 16'h0000;
      bg_q        <= 16'h0000;
      swap_q      <= 1'b0;
      frame_count <= 8'd0;
    end else begin
      swap_q <= 1'b0;
      if (state == IDLE && enable) begin
        bar_q   <= bar_color;
        bg_q    <= bg_color;
        bin_idx <= '0;
      end
      if (state == LOAD && bus.bin_valid) begin
        h[bin_idx] <= h_new;
        bin_idx    <= bin_idx + BW'(1);
      end
      if (pix_acc) begin
        addr <= addr + 32'd2;
        if (x == XW'(H_RES - 1)) begin
          x   <= '0;
          col <= '0;
          bar <= '0;
          y   <= last_pix ? '0 : y + YW'(1);
        end else begin
          x <= x + XW'(1);
          if (col == CW'(BAR_W - 1)) begin
            col <= '0;
            bar <= bar + BW'(1);
          end else begin
            col <= col + CW'(1);
          end
        end
        // rewind for the next frame and raise the one-cycle swap request
        if (last_pix) begin
          addr   <= BASE_ADDR;
          swap_q <= 1'b1;
        end
      end
      if (state == SWAP && bus.swap_done) frame_count <= frame_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_spectrum_draw_ctrl.sv
// Directed bench for spectrum_draw_ctrl with a pixel-write scoreboard.
// Small geometry: 16x8 pixels, 4 bars of width 4, magnitude shift 4.
module tb_spectrum_draw_ctrl;

  localparam logic [15:0] BAR = 16'hF800;
  localparam logic [15:0] BG  = 16'h001F;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] bar_color = BAR;
  logic [15:0] bg_color = BG;
  logic [15:0] bin_mag = 16'h0;
  logic        bin_valid = 1'b0;
  logic        wait_rq = 1'b0;
  logic        stall_en = 1'b0;
  logic        resp_done = 1'b0;
  logic        spur_done = 1'b0;
  int          swap_delay = 2;
  logic        busy;
  logic [7:0]  frame_count;

  spectrum_draw_if #(.MAG_W(16)) bus ();

  assign bus.bin_mag       = bin_mag;
  assign bus.bin_valid     = bin_valid;
  assign bus.m_waitrequest = wait_rq;
  assign bus.swap_done     = resp_done | spur_done;

  spectrum_draw_ctrl #(
    .H_RES(16), .V_RES(8), .NUM_BARS(4),
    .MAG_W(16), .MAG_SHIFT(4), .BASE_ADDR(32'h0)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .bar_color(bar_color), .bg_color(bg_color),
    .bus(bus), .busy(busy), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          wr_cnt = 0;
  int          swap_cnt = 0;
  int          beats = 0;
  bit          sb_on = 1'b0;
  logic [47:0] sb_q [$];
  logic [47:0] req;
  logic [15:0] mem [128];
  logic [15:0] mags [4];
  logic [31:0] last_addr = 32'h0;
  logic        prev_stall = 1'b0;
  logic        prev_swap = 1'b0;
  logic [31:0] prev_a = 32'h0;
  logic [15:0] prev_d = 16'h0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Bus monitor: writes, stall hold, swap pulse width, accepted bins
  initial forever begin
    @(negedge clk);
    if (prev_stall) begin
      check("stall_write", 32'(bus.m_write), 32'd1);
      check("stall_addr", bus.m_address, prev_a);
      check("stall_data", 32'(bus.m_writedata), 32'(prev_d));
    end
    if (bus.m_write && !bus.m_waitrequest) begin
      wr_cnt++;
      last_addr = bus.m_address;
      mem[bus.m_address[7:1]] = bus.m_writedata;
      if (sb_on) begin
        if (sb_q.size() == 0) begin
          check("extra_write", bus.m_address, 32'hFFFF_FFFF);
        end else begin
          req = sb_q.pop_front();
          check("wr_addr", bus.m_address, req[47:16]);
          check("wr_data", 32'(bus.m_writedata), 32'(req[15:0]));
        end
      end
    end
    if (bus.swap_req) begin
      swap_cnt++;
      check("swap_pulse_width", 32'(prev_swap), 32'd0);
    end
    if (bus.bin_valid && bus.bin_ready) beats++;
    prev_stall = bus.m_write && bus.m_waitrequest && !reset;
    prev_a     = bus.m_address;
    prev_d     = bus.m_writedata;
    prev_swap  = bus.swap_req;
  end

  initial forever begin
    @(posedge clk);
    #1;
    wait_rq = stall_en ? 1'($urandom_range(0, 1)) : 1'b0;
  end

  // Pixel DMA model: acknowledges each swap request after swap_delay cycles
  initial forever begin
    @(negedge clk);
    if (bus.swap_req) begin
      repeat (swap_delay) @(posedge clk);
      #1 resp_done = 1'b1;
      @(posedge clk);
      #1 resp_done = 1'b0;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic nclk();
    @(negedge clk);
    #1;
  endtask

  task automatic push_frame();
    int hh;
    bit lit;
    for (int y = 0; y < 8; y++) begin
      for (int x = 0; x < 16; x++) begin
        hh = int'(mags[x / 4] >> 4);
        if (hh > 8) hh = 8;
        lit = (y >= 8 - hh) && (x % 4 != 3);
        sb_q.push_back({32'(2 * (y * 16 + x)), lit ? bar_color : bg_color});
      end
    end
  endtask

  task automatic send_bins(input int gap);
    int n;
    for (int i = 0; i < 4; i++) begin
      bin_mag   = mags[i];
      bin_valid = 1'b1;
      n = 0;
      while (1) begin
        @(negedge clk);
        if (bus.bin_ready) break;
        n++;
        if (n > 3000) begin
          check("bin_ready_timeout", 32'(bus.bin_ready), 32'd1);
          bin_valid = 1'b0;
          return;
        end
      end
      @(posedge clk);
      #1;
      bin_valid = 1'b0;
      if (gap > 0) step(gap);
    end
  endtask

  task automatic wait_frame();
    logic [7:0] f0;
    int n;
    f0 = frame_count;
    n = 0;
    while (frame_count == f0) begin
      nclk();
      n++;
      if (n > 3000) begin
        check("frame_timeout", 32'(frame_count), 32'(f0 + 8'd1));
        return;
      end
    end
  endtask

  task automatic wait_wr(input int target);
    int n;
    n = 0;
    while (wr_cnt < target) begin
      nclk();
      n++;
      if (n > 3000) begin
        check("write_timeout", 32'(wr_cnt), 32'(target));
        return;
      end
    end
  endtask

  task automatic wait_swap();
    int n;
    n = 0;
    while (!bus.swap_req) begin
      nclk();
      n++;
      if (n > 3000) begin
        check("swap_timeout", 32'(bus.swap_req), 32'd1);
        return;
      end
    end
  endtask

  initial begin
    int w0;
    int s0;
    int b0;
    logic [7:0] f0;

    mags = '{16'h0000, 16'h0030, 16'h0080, 16'hFFFF};
    step(3);
    check("rst_bin_ready", 32'(bus.bin_ready), 32'd0);
    check("rst_m_write", 32'(bus.m_write), 32'd0);
    check("rst_m_address", bus.m_address, 32'h0);
    check("rst_m_writedata", 32'(bus.m_writedata), 32'd0);
    check("rst_swap_req", 32'(bus.swap_req), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frame_count", 32'(frame_count), 32'd0);

    // Scenario 1: basic frame, colour change mid-frame ignored
    reset  = 1'b0;
    enable = 1'b1;
    push_frame();
    sb_on = 1'b1;
    w0 = wr_cnt;
    s0 = swap_cnt;
    send_bins(0);
    wait_wr(w0 + 5);
    bar_color = 16'h07E0;
    bg_color  = 16'hFFFF;
    step(10);
    bar_color = BAR;
    bg_color  = BG;
    wait_frame();
    check("s1_writes", 32'(wr_cnt - w0), 32'd128);
    check("s1_swaps", 32'(swap_cnt - s0), 32'd1);
    check("s1_sb_empty", 32'(sb_q.size()), 32'd0);
    check("s1_frame_count", 32'(frame_count), 32'd1);
    check("px_4_5", 32'(mem[5 * 16 + 4]), 32'(BAR));
    check("px_4_4", 32'(mem[4 * 16 + 4]), 32'(BG));
    for (int y = 0; y < 8; y++) begin
      check("px_gap_7", 32'(mem[y * 16 + 7]), 32'(BG));
      for (int x = 0; x < 3; x++)
        check("px_bar0", 32'(mem[y * 16 + x]), 32'(BG));
    end

    // Scenario 2: random waitrequest stalls
    stall_en = 1'b1;
    push_frame();
    w0 = wr_cnt;
    send_bins(0);
    wait_frame();
    stall_en = 1'b0;
    check("s2_writes", 32'(wr_cnt - w0), 32'd128);
    check("s2_last_addr", last_addr, 32'd254);
    check("s2_sb_empty", 32'(sb_q.size()), 32'd0);

    // Scenario 3: gapped bins, fifth beat refused
    mags = '{16'h0010, 16'h0050, 16'h0070, 16'h0020};
    push_frame();
    w0 = wr_cnt;
    b0 = beats;
    send_bins(2);
    check("s3_beats", 32'(beats - b0), 32'd4);
    bin_mag   = 16'hABCD;
    bin_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      nclk();
      check("s3_no_ready", 32'(bus.bin_ready), 32'd0);
    end
    bin_valid = 1'b0;
    check("s3_beats_after", 32'(beats - b0), 32'd4);
    wait_frame();
    check("s3_writes", 32'(wr_cnt - w0), 32'd128);

    // Scenario 4: slow swap_done, spurious swap_done during DRAW
    swap_delay = 20;
    push_frame();
    w0 = wr_cnt;
    f0 = frame_count;
    send_bins(0);
    wait_wr(w0 + 10);
    spur_done = 1'b1;
    step(1);
    spur_done = 1'b0;
    nclk();
    check("s4_spurious", 32'(frame_count), 32'(f0));
    wait_swap();
    for (int i = 0; i < 19; i++) begin
      nclk();
      check("s4_swap_wait", {30'd0, bus.m_write, busy}, 32'd1);
    end
    wait_frame();
    check("s4_frame_inc", 32'(frame_count), 32'(f0 + 8'd1));
    swap_delay = 2;

    // Scenario 5: reset during the 50th write, then a clean frame
    sb_on = 1'b0;
    w0 = wr_cnt;
    send_bins(0);
    wait_wr(w0 + 50);
    reset = 1'b1;
    step(1);
    check("s5_m_write", 32'(bus.m_write), 32'd0);
    check("s5_idle", 32'(busy), 32'd0);
    check("s5_frame_count", 32'(frame_count), 32'd0);
    check("s5_m_address", bus.m_address, 32'h0);
    reset = 1'b0;
    sb_q.delete();
    push_frame();
    sb_on = 1'b1;
    w0 = wr_cnt;
    send_bins(0);
    wait_frame();
    check("s5_writes", 32'(wr_cnt - w0), 32'd128);
    check("s5_sb_empty", 32'(sb_q.size()), 32'd0);
    check("s5_frame_count_1", 32'(frame_count), 32'd1);

    // Scenario 6: frame counter wrap, then enable drop mid-DRAW
    mags = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
    for (int f = 0; f < 255; f++) begin
      push_frame();
      send_bins(0);
      wait_frame();
    end
    check("s6_wrap", 32'(frame_count), 32'd0);
    mags = '{16'h0040, 16'h0060, 16'h0010, 16'h0090};
    push_frame();
    w0 = wr_cnt;
    s0 = swap_cnt;
    send_bins(0);
    wait_wr(w0 + 10);
    enable = 1'b0;
    wait_frame();
    check("s6_writes", 32'(wr_cnt - w0), 32'd128);
    check("s6_swaps", 32'(swap_cnt - s0), 32'd1);
    for (int i = 0; i < 5; i++) begin
      nclk();
      check("s6_idle", {29'd0, busy, bus.bin_ready, bus.m_write}, 32'd0);
    end
    check("s6_frame_count", 32'(frame_count), 32'd1);
    check("s6_sb_empty", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
